// File: rtl/alarm_seq_ctrl_pkg.sv
// alarm_seq_ctrl_pkg: shared alarm-clock constants, state encoding and default timing
package alarm_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RING    = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam int RING_MAX_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;

endpackage

// File: rtl/alarm_seq_ctrl_edge_det.sv
// edge_det: rising-edge detector giving a single-cycle pulse per low-to-high transition
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev;

    // remember last sample; resets low so a level high at release counts as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= 1'b0;
        else
            prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/alarm_seq_ctrl.sv
// alarm_seq_ctrl: alarm ring / snooze / lockout sequencer driving the buzzer enable
module alarm_seq_ctrl
    import alarm_seq_ctrl_pkg::*;
#(
    parameter int RING_MAX   = RING_MAX_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_match,
    input  logic       i_alarm_en,
    input  logic       i_sw_snooze,
    input  logic       i_sw_stop,
    output logic       o_buzz_en,
    output logic [1:0] o_state,
    output logic [2:0] o_snooze_cnt,
    output logic [5:0] o_ring_sec
);

    state_t     state, n_state;
    logic [2:0] n_cnt;
    logic [5:0] n_sec;
    logic [8:0] tmr, n_tmr;
    logic       match_e, snz_e, stop_e;

    edge_det u_match (.clk(clk), .rst_n(rst_n), .d(i_match),     .rise(match_e));
    edge_det u_snz   (.clk(clk), .rst_n(rst_n), .d(i_sw_snooze), .rise(snz_e));
    edge_det u_stop  (.clk(clk), .rst_n(rst_n), .d(i_sw_stop),   .rise(stop_e));

    // next state: disarm beats everything, then stop, then snooze, then the 1 Hz tick
    always_comb begin
        n_state = state;
        n_cnt   = o_snooze_cnt;
        n_sec   = o_ring_sec;
        n_tmr   = tmr;
        if (!i_alarm_en) begin
            n_state = ST_IDLE;
            n_cnt   = '0;
            n_sec   = '0;
            n_tmr   = '0;
        end else begin
            case (state)
                ST_IDLE: if (match_e) begin
                    n_state = ST_RING;
                    n_cnt   = '0;
                    n_sec   = '0;
                end
                ST_RING: if (stop_e) begin
                    n_state = ST_LOCKOUT;
                end else if (snz_e && o_snooze_cnt < 3'(MAX_SNOOZE)) begin
                    n_state = ST_SNOOZE;
                    n_cnt   = o_snooze_cnt + 3'd1;
                    n_tmr   = 9'(SNOOZE_SEC);
                end else if (i_tick_1hz) begin
                    n_state = (o_ring_sec == 6'(RING_MAX - 1)) ? ST_LOCKOUT : ST_RING;
                    n_sec   = (o_ring_sec == 6'(RING_MAX - 1)) ? 6'd0 : o_ring_sec + 6'd1;
                end
                ST_SNOOZE: if (stop_e) begin
                    n_state = ST_LOCKOUT;
                end else if (i_tick_1hz) begin
                    n_tmr = (tmr != 9'd0) ? tmr - 9'd1 : tmr;
                    if (tmr == 9'd1) begin
                        n_state = ST_RING;
                        n_sec   = '0;
                    end
                end
                ST_LOCKOUT: if (!i_match) begin
                    n_state = ST_IDLE;
                    n_cnt   = '0;
                end
            endcase
        end
    end

    // state, counters, timer and buzzer enable all registered; reset silences the buzzer at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            o_snooze_cnt <= '0;
            o_ring_sec   <= '0;
            tmr          <= '0;
            o_buzz_en    <= 1'b0;
        end else begin
            state        <= n_state;
            o_snooze_cnt <= n_cnt;
            o_ring_sec   <= n_sec;
            tmr          <= n_tmr;
            o_buzz_en    <= (n_state == ST_RING);
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// tb_alarm_seq_ctrl: directed bench with a cycle model of the alarm rules and literal spot checks
module tb_alarm_seq_ctrl;

    localparam int RMAX = 5;
    localparam int SNZ  = 3;
    localparam int MAXS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, match = 1'b0, en = 1'b0, snz = 1'b0, stop = 1'b0;
    logic       buzz;
    logic [1:0] st;
    logic [2:0] cnt;
    logic [5:0] sec;

    int vectors = 0;
    int errors  = 0;

    alarm_seq_ctrl #(.RING_MAX(RMAX), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick_1hz(tick), .i_match(match),
        .i_alarm_en(en), .i_sw_snooze(snz), .i_sw_stop(stop),
        .o_buzz_en(buzz), .o_state(st), .o_snooze_cnt(cnt), .o_ring_sec(sec)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 ringing, 2 snoozing, 3 locked out
    int mode = 0, used = 0, rsec = 0, left = 0;
    bit was_match = 0, was_snz = 0, was_stop = 0;

    initial forever begin
        bit m_ev, z_ev, s_ev;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mode = 0; used = 0; rsec = 0; left = 0;
            was_match = 0; was_snz = 0; was_stop = 0;
        end else begin
            m_ev = match && !was_match;
            z_ev = snz && !was_snz;
            s_ev = stop && !was_stop;
            was_match = match; was_snz = snz; was_stop = stop;
            if (!en) begin
                mode = 0; used = 0; rsec = 0; left = 0;
            end else if (mode == 0) begin
                if (m_ev) begin mode = 1; used = 0; rsec = 0; end
            end else if (mode == 1) begin
                if (s_ev) mode = 3;
                else if (z_ev && used < MAXS) begin mode = 2; used++; left = SNZ; end
                else if (tick) begin
                    rsec++;
                    if (rsec == RMAX) begin mode = 3; rsec = 0; end
                end
            end else if (mode == 2) begin
                if (s_ev) mode = 3;
                else if (tick) begin
                    left--;
                    if (left == 0) begin mode = 1; rsec = 0; end
                end
            end else if (!match) begin
                mode = 0; used = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: outputs must match the model
    always @(negedge clk) begin
        chk("model_state", int'(st), mode);
        chk("model_buzz", int'(buzz), (mode == 1) ? 1 : 0);
        chk("model_cnt", int'(cnt), used);
        chk("model_sec", int'(sec), rsec);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    initial begin
        #3;
        chk("reset_state", int'(st), 0);
        chk("reset_buzz", int'(buzz), 0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_sec", int'(sec), 0);
        #9 rst_n = 1'b1;
        step();

        // basic ring and timeout
        en = 1'b1; step();
        match = 1'b1; step();
        chk("ring_state", int'(st), 1);
        chk("ring_buzz", int'(buzz), 1);
        ticks(4);
        chk("ring_sec4", int'(sec), 4);
        ticks(1);
        chk("timeout_state", int'(st), 3);
        chk("timeout_buzz", int'(buzz), 0);
        chk("timeout_sec", int'(sec), 0);
        step(3);
        chk("lock_hold", int'(st), 3);
        match = 1'b0; step();
        chk("lock_release", int'(st), 0);

        // snooze path up to the snooze limit
        match = 1'b1; step();
        snz = 1'b1; step();
        chk("snz1_state", int'(st), 2);
        chk("snz1_cnt", int'(cnt), 1);
        snz = 1'b0; step();
        ticks(2);
        chk("snz_wait", int'(st), 2);
        ticks(1);
        chk("snz_back_state", int'(st), 1);
        chk("snz_back_sec", int'(sec), 0);
        snz = 1'b1; step();
        chk("snz2_cnt", int'(cnt), 2);
        snz = 1'b0; step();
        ticks(3);
        chk("snz2_back", int'(st), 1);
        snz = 1'b1; step();
        chk("snz_limit_state", int'(st), 1);
        chk("snz_limit_cnt", int'(cnt), 2);
        snz = 1'b0; step();

        // simultaneous stop and snooze, then stop held
        stop = 1'b1; snz = 1'b1; step();
        chk("both_state", int'(st), 3);
        chk("both_cnt", int'(cnt), 2);
        step(10);
        chk("stop_held", int'(st), 3);
        snz = 1'b0; match = 1'b0; step();
        chk("stop_idle", int'(st), 0);
        stop = 1'b0; step();

        // re-trigger guard
        match = 1'b1; step();
        chk("retrig_ring", int'(st), 1);
        stop = 1'b1; step();
        stop = 1'b0;
        step(20);
        chk("retrig_lock", int'(st), 3);
        match = 1'b0; step();
        match = 1'b1; step();
        chk("fresh_ring", int'(st), 1);

        // snooze switch held across the snooze period gives one event only
        snz = 1'b1; step();
        ticks(3);
        step(4);
        chk("held_snz_state", int'(st), 1);
        chk("held_snz_cnt", int'(cnt), 1);
        snz = 1'b0; step();

        // disarm while snoozing with two seconds left
        snz = 1'b1; step();
        ticks(1);
        chk("disarm_pre", int'(st), 2);
        en = 1'b0; step();
        chk("disarm_state", int'(st), 0);
        chk("disarm_cnt", int'(cnt), 0);
        ticks(4);
        chk("disarm_buzz", int'(buzz), 0);
        snz = 1'b0; match = 1'b0; step();
        en = 1'b1; match = 1'b1; step();
        chk("rearm_ring", int'(st), 1);

        // asynchronous reset mid-ring, match high on release
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_buzz", int'(buzz), 0);
        chk("async_state", int'(st), 0);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_cnt", int'(cnt), 0);
        chk("rel_sec", int'(sec), 0);
        chk("rel_buzz", int'(buzz), 0);
        @(posedge clk);
        #2;
        chk("rel_first_edge", int'(st), 1);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alarm_seq_ctrl.md
ALARM_SEQ_CTRL -- requirements
Module: alarm_seq_ctrl

Interface
REQ-001 The block SHALL have parameter RING_MAX, default 60, meaning the ring timeout in seconds (1..63).
REQ-002 The block SHALL have parameter SNOOZE_SEC, default 300, meaning the snooze duration in seconds (1..511).
REQ-003 The block SHALL have parameter MAX_SNOOZE, default 3, meaning the snoozes allowed per alarm event (0..7).
REQ-004 clk  input  1  system clock, the single clock of the block.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_tick_1hz  input  1  one-clk-wide strobe, once per second.
REQ-007 i_match  input  1  level, high while clock time equals alarm time.
REQ-008 i_alarm_en  input  1  level, alarm armed.
REQ-009 i_sw_snooze  input  1  debounced level, active-high, snooze request.
REQ-010 i_sw_stop  input  1  debounced level, active-high, stop request.
REQ-011 o_buzz_en  output  1  enable to the buzzer melody generator.
REQ-012 o_state  output  2  current state: IDLE=0, RING=1, SNOOZE=2, LOCKOUT=3.
REQ-013 o_snooze_cnt  output  3  number of snoozes used in the current event.
REQ-014 o_ring_sec  output  6  seconds elapsed in the current ring.

Function
REQ-015 i_match, i_sw_snooze and i_sw_stop SHALL each be rising-edge detected internally (previous-value register), giving single-cycle events match_e, snz_e and stop_e.
REQ-016 Event priority within one cycle SHALL be: i_alarm_en low > stop_e > snz_e > tick/timeout.
REQ-017 When i_alarm_en is low, the next state SHALL be IDLE from any state, and o_snooze_cnt and o_ring_sec SHALL be cleared.
REQ-018 IDLE: match_e with i_alarm_en high SHALL move to RING, with o_ring_sec=0 and o_snooze_cnt=0.
REQ-019 RING on stop_e: SHALL move to LOCKOUT.
REQ-020 RING on snz_e with o_snooze_cnt<MAX_SNOOZE: SHALL move to SNOOZE, increment o_snooze_cnt, and load snooze timer=SNOOZE_SEC.
REQ-021 RING on snz_e with o_snooze_cnt==MAX_SNOOZE: the event SHALL be ignored and the block SHALL stay in RING.
REQ-022 RING on tick: o_ring_sec SHALL increment; on a tick with o_ring_sec==RING_MAX-1, the block SHALL move to LOCKOUT instead, with o_ring_sec=0.
REQ-023 SNOOZE on tick: the timer SHALL decrement; on a tick with timer==1, the block SHALL move to RING with o_ring_sec=0.
REQ-024 SNOOZE on stop_e: SHALL move to LOCKOUT; snz_e SHALL be ignored.
REQ-025 LOCKOUT: when i_match is low, SHALL move to IDLE and clear o_snooze_cnt; this prevents re-trigger while the match level persists.
REQ-026 match_e SHALL be ignored in every state except IDLE.
REQ-027 o_buzz_en SHALL be 1 exactly while the state register holds RING; an event sampled at edge N is reflected on outputs after edge N (latency 1 clk).
REQ-028 The 9-bit snooze timer and the 6-bit ring counter SHALL never wrap; loads take precedence over decrement/increment.
REQ-029 A switch held high SHALL produce only one event; release-and-press is needed for another.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, o_buzz_en=0, o_snooze_cnt=0, o_ring_sec=0, snooze timer=0, and all edge registers=0.
REQ-031 Reset mid-RING or mid-SNOOZE SHALL silence the buzzer immediately, without waiting for clk.
REQ-032 The edge registers SHALL reset to 0, so an input that is high on reset release SHALL create an event on the first clk edge.

Structure
REQ-033 The state encodings and the default parameter values SHALL reside in the shared clock-project constants package/header.
REQ-034 One sub-module, edge_det (rising-edge detector, clk/rst_n), SHALL be instantiated three times.
REQ-035 The next-state logic SHALL be one combinational block, and the state, counters and timer SHALL be registered in one clocked block.

Verification (use RING_MAX=5, SNOOZE_SEC=3, MAX_SNOOZE=2)
REQ-036 Basic ring: en=1, match rises -> o_state=1 and o_buzz_en=1 the next clk; 5 ticks -> o_state=3, buzz=0; match falls -> o_state=0.
REQ-037 Snooze path: RING, snooze press -> state 2, cnt=1; 3 ticks -> state 1, ring_sec=0; snooze -> cnt=2; snooze again later in RING -> stays RING, cnt=2.
REQ-038 Simultaneous events: stop and snooze rise in the same clk during RING -> state 3, cnt unchanged; holding stop high 10 clks -> a single event only.
REQ-039 Disarm: i_alarm_en drops during SNOOZE with timer=2 -> state 0, cnt=0, no buzz at the following ticks.
REQ-040 Re-trigger guard: after stop, match stays high 20 clks -> remains LOCKOUT; a fresh match rise after IDLE -> RING.
REQ-041 Reset mid-RING: rst_n pulsed low between clk edges -> o_buzz_en=0 asynchronously; all outputs zero after release.
